// File: rtl/ram128x1_serial_loader.sv
// Writable 128x1 distributed RAM with an asynchronous ROM-compatible read port and a
// valid/ready serial bulk loader. Define RAM128X1_READ_REG_EN to register DO0 (1-cycle read latency).
module ram128x1_serial_loader #(
    parameter logic [127:0] initval = 128'h0,
    localparam int RAD_W = 7
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             WRE,
    input  logic [RAD_W-1:0] WAD,
    input  logic             DI,
    input  logic [RAD_W-1:0] RAD,
    output logic             DO0,
    input  logic             LOAD,
    input  logic             SDI,
    input  logic             SVALID,
    output logic             SREADY,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {IDLE, LOADING, FINISH} state_t;

    state_t           state;
    logic [127:0]     mem;
    logic [RAD_W-1:0] ptr;
    logic             rd_bit;

    // Binary mux tree built from ?: so an unknown select bit merges both halves:
    // identical candidates give that value, differing ones give X.
    function automatic logic mux_read(input logic [127:0] m, input logic [RAD_W-1:0] a);
        logic [127:0] v;
        logic [6:0]   lo;
        v = m;
        for (int k = 0; k < RAD_W; k++) begin
            for (int i = 0; i < (64 >> k); i++) begin
                lo = 7'(2 * i);
                v[i[6:0]] = a[k[2:0]] ? v[lo + 7'd1] : v[lo];
            end
        end
        return v[0];
    endfunction

    always_comb rd_bit = mux_read(mem, RAD);

`ifdef RAM128X1_READ_REG_EN
    // Sampled before the edge's write lands, so a same-cycle write returns old data.
    always_ff @(posedge CK) begin
        if (RST) DO0 <= initval[0];
        else     DO0 <= rd_bit;
    end
`else
    assign DO0 = rd_bit;
`endif

    always_ff @(posedge CK) begin
        if (RST) begin
            mem    <= initval;
            state  <= IDLE;
            ptr    <= '0;
            SREADY <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // An unknown enable or address on a possible write poisons the whole array.
                    if ($isunknown(WRE) || (WRE && $isunknown(WAD)))
                        mem <= 'x;
                    else if (WRE)
                        mem[WAD] <= DI;
                    if (LOAD) begin
                        state  <= LOADING;
                        ptr    <= '0;
                        SREADY <= 1'b1;
                        BUSY   <= 1'b1;
                    end
                end
                LOADING: begin
                    if (SVALID && SREADY) begin
                        mem[ptr] <= SDI;
                        ptr      <= ptr + 1'b1;
                        if (ptr == 7'd127) begin
                            state  <= FINISH;
                            SREADY <= 1'b0;
                            DONE   <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    SREADY <= 1'b0;
                    BUSY   <= 1'b0;
                    DONE   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram128x1_serial_loader.sv
// Directed bench for ram128x1_serial_loader (asynchronous read build).
module tb_ram128x1_serial_loader;

    localparam logic [127:0] INIT = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic       WRE = 1'b0;
    logic [6:0] WAD = '0;
    logic       DI = 1'b0;
    logic [6:0] RAD = '0;
    logic       DO0;
    logic       LOAD = 1'b0;
    logic       SDI = 1'b0;
    logic       SVALID = 1'b0;
    logic       SREADY, BUSY, DONE;

    int errors = 0;
    int checks = 0;

    ram128x1_serial_loader #(.initval(INIT)) dut (
        .CK(CK), .RST(RST), .WRE(WRE), .WAD(WAD), .DI(DI), .RAD(RAD), .DO0(DO0),
        .LOAD(LOAD), .SDI(SDI), .SVALID(SVALID), .SREADY(SREADY), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CK = ~CK;

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] addrs [3] = '{7'd0, 7'd127, 7'd5};
        logic       exps  [3] = '{1'b1, 1'b1, 1'b0};
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            RAD = addrs[i];
            #1;
            checks++;
            if (DO0 !== exps[i]) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%b want=%b", addrs[i], DO0, exps[i]);
            end
        end
        checks++;
        if ({BUSY, SREADY, DONE} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags busy/sready/done got=%b want=000", {BUSY, SREADY, DONE});
        end
    endtask

    task automatic test_random_write();
        logic [127:0] exp;
        int           bad;
        exp = INIT;
        WRE = 1'b1; WAD = 7'd64; DI = 1'b1;
        step();
        exp[64] = 1'b1;
        WRE = 1'b0;
        RAD = 7'd64;
        #1;
        checks++;
        if (DO0 !== 1'b1) begin
            errors++;
            $display("FAIL write64 got=%b want=1", DO0);
        end
        // Boundary writes, then a disabled write that must not land.
        WRE = 1'b1; WAD = 7'd0; DI = 1'b0;
        step();
        exp[0] = 1'b0;
        WAD = 7'd127; DI = 1'b0;
        step();
        exp[127] = 1'b0;
        WRE = 1'b0; WAD = 7'd5; DI = 1'b1;
        step();
        bad = 0;
        for (int a = 0; a < 128; a++) begin
            RAD = a[6:0];
            #1;
            if (DO0 !== exp[a]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL write_contents bad_bits=%0d want=0", bad);
        end
        // Restore the reset image for later tests.
        WRE = 1'b1; WAD = 7'd0; DI = 1'b1;
        step();
        WAD = 7'd127;
        step();
        WAD = 7'd64; DI = 1'b0;
        step();
        WRE = 1'b0;
    endtask

    // toggle=1: SVALID starts low and alternates, with a stray WRE mid-load.
    task automatic test_serial_load(input logic [127:0] pat, input bit toggle, input string name);
        int cycles, b, bad_flags, bad;
        int want_cycles;
        LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        cycles = 0; b = 0; bad_flags = 0;
        while (b < 128 && cycles < 1000) begin
            if (SREADY !== 1'b1 || BUSY !== 1'b1 || DONE !== 1'b0) bad_flags++;
            SVALID = toggle ? cycles[0] : 1'b1;
            SDI = pat[b];
            if (toggle && cycles >= 20 && cycles < 30) begin
                WRE = 1'b1; WAD = 7'd3; DI = ~pat[3]; LOAD = 1'b1;
            end else begin
                WRE = 1'b0; LOAD = 1'b0;
            end
            step();
            if (SVALID) b++;
            cycles++;
        end
        SVALID = 1'b0; WRE = 1'b0; LOAD = 1'b0;
        want_cycles = toggle ? 256 : 128;
        checks++;
        if (cycles != want_cycles || bad_flags != 0) begin
            errors++;
            $display("FAIL %s_loading cycles=%0d bad_flag_cycles=%0d want cycles=%0d bad=0",
                     name, cycles, bad_flags, want_cycles);
        end
        checks++;
        if ({DONE, BUSY, SREADY} !== 3'b110) begin
            errors++;
            $display("FAIL %s_finish done/busy/sready got=%b want=110", name, {DONE, BUSY, SREADY});
        end
        step();
        checks++;
        if ({DONE, BUSY, SREADY} !== 3'b000) begin
            errors++;
            $display("FAIL %s_idle done/busy/sready got=%b want=000", name, {DONE, BUSY, SREADY});
        end
        bad = 0;
        for (int a = 0; a < 128; a++) begin
            RAD = a[6:0];
            #1;
            if (DO0 !== pat[a]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_contents bad_bits=%0d want=0", name, bad);
        end
    endtask

    task automatic test_reset_mid_load();
        int bad, dones;
        LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        SVALID = 1'b1; SDI = 1'b0;
        for (int i = 0; i < 40; i++) step();
        dones = 0;
        RST = 1'b1;
        step();
        if (DONE !== 1'b0) dones++;
        RST = 1'b0; SVALID = 1'b0;
        checks++;
        if ({BUSY, SREADY} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_flags busy/sready got=%b want=00", {BUSY, SREADY});
        end
        bad = 0;
        for (int a = 0; a < 128; a++) begin
            RAD = a[6:0];
            #1;
            if (DO0 !== INIT[a]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_contents bad_bits=%0d want=0", bad);
        end
        for (int i = 0; i < 150; i++) begin
            step();
            if (DONE !== 1'b0 || BUSY !== 1'b0) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midreset_no_done stray_cycles=%0d want=0", dones);
        end
    endtask

    task automatic test_load_held();
        int n;
        LOAD = 1'b1;
        SVALID = 1'b1; SDI = 1'b1;
        step();
        n = 0;
        while (DONE !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        SVALID = 1'b0;
        checks++;
        if (n != 128) begin
            errors++;
            $display("FAIL held_load_len cycles=%0d want=128", n);
        end
        // Write attempted during FINISH must be dropped.
        WRE = 1'b1; WAD = 7'd10; DI = 1'b0;
        step();
        WRE = 1'b0;
        checks++;
        if ({BUSY, SREADY, DONE} !== 3'b000) begin
            errors++;
            $display("FAIL held_idle busy/sready/done got=%b want=000", {BUSY, SREADY, DONE});
        end
        step();
        checks++;
        if ({BUSY, SREADY} !== 2'b11) begin
            errors++;
            $display("FAIL held_restart busy/sready got=%b want=11", {BUSY, SREADY});
        end
        LOAD = 1'b0;
        RAD = 7'd10;
        #1;
        checks++;
        if (DO0 !== 1'b1) begin
            errors++;
            $display("FAIL finish_write_ignored got=%b want=1", DO0);
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic test_x_read();
        logic [6:0] rad_x;
        WRE = 1'b1; WAD = 7'd1; DI = 1'b1;
        step();
        WRE = 1'b0;
        rad_x = 7'b000000x;
        RAD = rad_x;
        #1;
        checks++;
        if (DO0 !== 1'b1) begin
            errors++;
            $display("FAIL xread_common got=%b want=1", DO0);
        end
        RAD = 7'd2;
        #1;
        checks++;
        if (DO0 !== 1'b0) begin
            errors++;
            $display("FAIL xread_neighbour got=%b want=0", DO0);
        end
    endtask

    initial begin
        test_reset();
        test_random_write();
        test_serial_load(PAT_A5, 1'b0, "a5_stream");
        RAD = 7'd0;
        #1;
        checks++;
        if (DO0 !== 1'b1) begin
            errors++;
            $display("FAIL a5_bit0 got=%b want=1", DO0);
        end
        RAD = 7'd1;
        #1;
        checks++;
        if (DO0 !== 1'b0) begin
            errors++;
            $display("FAIL a5_bit1 got=%b want=0", DO0);
        end
        test_serial_load(PAT_B, 1'b1, "toggle_stream");
        test_reset_mid_load();
        test_load_held();
        test_x_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule
